switch_input_conditioner: RTL

- Upstream conditioning stage for the 5-input combinational function blocks of the lab set (mux-tree logic driven by a 5-bit `in` vector).
- Takes raw board switch/button levels, which are asynchronous and bouncy, and synchronises each bit with a 2-flop synchroniser.
- Debounces each bit with its own stability counter, paced by a shared prescaler tick.
- Presents a clean 5-bit vector plus per-bit edge pulses and a combined change strobe, for downstream logic and its output capture.

---
 rtl/switch_input_conditioner.sv | 80 ++++++++
 1 files changed

// File: rtl/switch_input_conditioner.sv
// Switch input conditioner: 2-flop sync, per-bit debounce, edge pulses.
// Presents a clean level vector plus rise/fall/changed strobes.
module switch_input_conditioner #(
  parameter int WIDTH        = 5,
  parameter int PRESCALE     = 1,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         s1;
  logic [WIDTH-1:0]         s2;
  logic [PW-1:0]            pre;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;
  logic [WIDTH-1:0]         diff;
  logic [WIDTH-1:0]         nxt_out;
  logic [WIDTH-1:0]         nxt_rise;
  logic [WIDTH-1:0]         nxt_fall;

  assign tick = (pre == PRE_LAST);
  assign diff = s2 ^ sw_out;

  // Any disagreement that is not backed by a tick simply holds its count.
  always_comb begin
    nxt_out  = sw_out;
    nxt_rise = '0;
    nxt_fall = '0;
    cnt_nxt  = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (1'b1)
        !diff[i]: cnt_nxt[i] = '0;
        diff[i] && !tick: cnt_nxt[i] = cnt[i];
        diff[i] && tick && (cnt[i] != CNT_LAST):
          cnt_nxt[i] = cnt[i] + CW'(1);
        default: begin
          cnt_nxt[i]  = '0;
          nxt_out[i]  = s2[i];
          nxt_rise[i] = s2[i];
          nxt_fall[i] = ~s2[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      pre     <= '0;
      cnt     <= '0;
      sw_out  <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      s1      <= sw_in;
      s2      <= s1;
      pre     <= tick ? '0 : pre + PW'(1);
      cnt     <= cnt_nxt;
      sw_out  <= nxt_out;
      rise    <= nxt_rise;
      fall    <= nxt_fall;
      changed <= |(nxt_rise | nxt_fall);
    end
  end

endmodule
